// File: rtl/i2c_pkg.sv
// Shared types for the byte-level I2C master: FSM states, quarter phases, byte size.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WBIT,
        RACK,
        RBIT,
        WACK,
        STOP,
        HOLD
    } i2c_state_e;

    // Quarter-phase encodings within one bus slot
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-period timebase: divides sys_clk into SCL quarters and tracks the phase in the slot.
module i2c_qtick_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125,
    parameter int CNT_W   = $clog2(CLK_DIV)
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       restart,
    output logic       qtick,
    output logic [1:0] phase,
    output logic       last_cycle_q2
);

    logic [CNT_W-1:0] cnt;

    assign qtick         = (cnt == CNT_W'(CLK_DIV - 1));
    assign last_cycle_q2 = qtick && (phase == Q2);

    // Count cycles within a quarter; restart re-aligns the slot to q0 on command accept
    always_ff @(posedge sys_clk) begin
        if (sys_rst || restart) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (qtick) begin
            cnt   <= '0;
            phase <= phase + 2'd1;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2c_master_byte.sv
// Byte-level I2C master: optional (repeated) START, one byte write/read with ACK, optional STOP.
module i2c_master_byte
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125,
    parameter int CNT_W   = $clog2(CLK_DIV)
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic       cmd_nack,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       bus_held,
    output logic       scl,
    inout  wire        sda
);

    i2c_state_e state, state_nx;
    logic [1:0] phase;
    logic       qtick, last_q2, slot_end, accept, mid, last_bit, complete;
    logic [2:0] bit_cnt;
    logic       c_stop, c_read, c_nack;
    logic [7:0] c_wdata;
    logic [7:0] shift;
    logic       ack_smp, hold_low, sda_low;
    logic [1:0] sda_sync;

    i2c_qtick_gen #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) u_qtick (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .restart       (accept),
        .qtick         (qtick),
        .phase         (phase),
        .last_cycle_q2 (last_q2)
    );

    assign cmd_ready = (state == IDLE) || (state == HOLD);
    assign busy      = !cmd_ready;
    assign accept    = cmd_valid && cmd_ready;
    assign slot_end  = qtick && (phase == Q3);
    assign mid       = (phase == Q1) || (phase == Q2);
    assign last_bit  = (bit_cnt == 3'(BITS_PER_BYTE - 1));
    assign complete  = slot_end && (((state == RACK || state == WACK) && !c_stop) || state == STOP);

    // Open drain: only ever pull low or release
    assign sda = sda_low ? 1'b0 : 1'bz;

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nx;
    end

    // Next state and pin drive, decoded from registered state and quarter phase
    always_comb begin
        state_nx = state;
        scl      = 1'b0;
        sda_low  = 1'b0;
        case (state)
            IDLE, HOLD: begin
                scl     = (state == IDLE);
                sda_low = (state == HOLD) && hold_low;
                // a free bus always needs a START, whatever cmd_start says
                if (accept)
                    state_nx = (cmd_start || !bus_held) ? START : (cmd_read ? RBIT : WBIT);
            end
            START: begin
                scl     = (phase == Q0) ? !bus_held : (phase != Q3);
                sda_low = phase[1];
                if (slot_end) state_nx = c_read ? RBIT : WBIT;
            end
            WBIT: begin
                scl     = mid;
                sda_low = !c_wdata[3'd7 - bit_cnt];
                if (slot_end && last_bit) state_nx = RACK;
            end
            RBIT: begin
                scl = mid;
                if (slot_end && last_bit) state_nx = WACK;
            end
            RACK, WACK: begin
                scl     = mid;
                sda_low = (state == WACK) && !c_nack;
                if (slot_end) state_nx = c_stop ? STOP : HOLD;
            end
            STOP: begin
                scl     = (phase != Q0);
                sda_low = !phase[1];
                if (slot_end) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Two-flop synchroniser on the shared SDA line
    always_ff @(posedge sys_clk) begin
        if (sys_rst) sda_sync <= 2'b11;
        else         sda_sync <= {sda_sync[0], sda};
    end

    // Command latch, bit counter, bus ownership, sampling and response
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            c_stop    <= 1'b0;
            c_read    <= 1'b0;
            c_nack    <= 1'b0;
            c_wdata   <= 8'h00;
            bit_cnt   <= 3'd0;
            bus_held  <= 1'b0;
            hold_low  <= 1'b0;
            shift     <= 8'h00;
            ack_smp   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_nack  <= 1'b0;
        end else begin
            rsp_valid <= complete;
            if (accept) begin
                c_stop  <= cmd_stop;
                c_read  <= cmd_read;
                c_nack  <= cmd_nack;
                c_wdata <= cmd_wdata;
                bit_cnt <= 3'd0;
            end
            if (last_q2 && state == RBIT) shift   <= {shift[6:0], sda_sync[1]};
            if (last_q2 && state == RACK) ack_smp <= sda_sync[1];
            if (slot_end) begin
                if (state == START)                   bus_held <= 1'b1;
                if (state == STOP)                    bus_held <= 1'b0;
                if (state == WBIT || state == RBIT)   bit_cnt  <= bit_cnt + 3'd1;
                // remember the ACK-slot level so HOLD keeps SDA where it was
                if (state == RACK || state == WACK)   hold_low <= (state == WACK) && !c_nack;
            end
            if (complete) begin
                rsp_rdata <= c_read ? shift : 8'h00;
                rsp_nack  <= c_read ? 1'b0 : ack_smp;
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Self-checking bench for i2c_master_byte with a behavioural I2C slave on the bus.
module tb_i2c_master_byte;

    localparam int CLK_DIV = 4;
    localparam int SLOT    = 4 * CLK_DIV;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_nack;
    logic [7:0] cmd_wdata;
    logic       cmd_ready, rsp_valid, rsp_nack, busy, bus_held, scl;
    logic [7:0] rsp_rdata;
    wire        sda_w;
    logic       slv_low;

    pullup (sda_w);
    assign sda_w = slv_low ? 1'b0 : 1'bz;

    always #5 sys_clk = ~sys_clk;

    i2c_master_byte #(.CLK_DIV(CLK_DIV)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_stop  (cmd_stop),
        .cmd_read  (cmd_read),
        .cmd_nack  (cmd_nack),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_nack  (rsp_nack),
        .busy      (busy),
        .bus_held  (bus_held),
        .scl       (scl),
        .sda       (sda_w)
    );

    // ---------------- behavioural slave ----------------
    // plan for the current command, written only by arm()
    bit         p_rd, p_ack, p_gate;
    logic [7:0] p_byte;
    int         arm_seq = 0;
    // bus observations, written only by the monitor process
    int         done_seq = 0, start_seq = 0;
    int         bitpos = 0, drv_idx = 15;
    int         n_start = 0, n_stop = 0, n_bytes = 0;
    logic [7:0] rx_sh = 8'h00, rx_byte = 8'h00;
    logic       rx_ack = 1'b0;
    logic       scl_q, sda_q;

    // slave drives read data bits, or the ACK after a written byte
    always @* begin
        slv_low = 1'b0;
        if (arm_seq != done_seq && !(p_gate && start_seq != arm_seq)) begin
            if (p_rd && drv_idx < 8)                 slv_low = !p_byte[3'(7 - drv_idx)];
            else if (!p_rd && p_ack && drv_idx == 8) slv_low = 1'b1;
        end
    end

    // bus monitor: START/STOP detection, bit sampling on SCL rise, drive update on SCL fall
    always @(scl or sda_w) begin
        if (scl === 1'b1 && scl_q === 1'b1 && sda_q === 1'b1 && sda_w === 1'b0) begin
            n_start++; bitpos = 0; drv_idx = 15; start_seq = arm_seq;
        end else if (scl === 1'b1 && scl_q === 1'b1 && sda_q === 1'b0 && sda_w === 1'b1) begin
            n_stop++; bitpos = 0; drv_idx = 15;
        end else if (scl === 1'b1 && scl_q !== 1'b1) begin
            if (bitpos < 8) rx_sh = {rx_sh[6:0], sda_w};
            else if (bitpos == 8) begin rx_byte = rx_sh; rx_ack = sda_w; n_bytes++; end
            bitpos++;
        end else if (scl === 1'b0 && scl_q === 1'b1) begin
            if (bitpos == 9) begin bitpos = 0; done_seq = arm_seq; end
            drv_idx = bitpos;
        end
        scl_q = scl;
        sda_q = sda_w;
    end

    task automatic arm(input bit rd, input bit ack, input logic [7:0] b, input bit gate);
        p_rd = rd; p_ack = ack; p_byte = b; p_gate = gate;
        arm_seq++;
    endtask

    // ---------------- checking ----------------
    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    typedef struct {
        bit         st, sp, rd, nk;
        logic [7:0] wd;
        bit         s_ack;
        logic [7:0] s_byte;
        int         lat;
        logic [7:0] rdata;
        bit         nack;
        bit         held;
    } vec_t;

    bit model_held = 1'b0;

    // reference: slot count from the command, response from what the slave does
    function automatic vec_t model(input vec_t v, input bit held);
        vec_t e = v;
        bit   es = v.st || !held;
        e.lat   = 1 + SLOT * (8 + 1 + int'(es) + int'(v.sp));
        e.rdata = v.rd ? v.s_byte : 8'h00;
        e.nack  = v.rd ? 1'b0 : !v.s_ack;
        e.held  = !v.sp;
        return e;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!cmd_ready && n < 2000) begin @(negedge sys_clk); n++; end
        if (!cmd_ready) chk({tag, " ready timeout"}, cmd_ready, 1);
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        int lat, s0, p0, b0;
        bit es;
        es = v.st || !model_held;
        arm(v.rd, v.s_ack, v.s_byte, es);
        s0 = n_start; p0 = n_stop; b0 = n_bytes;
        cmd_start = v.st; cmd_stop = v.sp; cmd_read = v.rd; cmd_nack = v.nk; cmd_wdata = v.wd;
        cmd_valid = 1'b1;
        wait_ready(tag);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        cmd_wdata = ~v.wd;
        lat = 1;
        while (!rsp_valid && lat < 2000) begin @(negedge sys_clk); lat++; end
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " rsp_rdata"}, rsp_rdata, v.rdata);
        chk({tag, " rsp_nack"}, rsp_nack, v.nack);
        chk({tag, " bus_held"}, bus_held, v.held);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " bus byte"}, rx_byte, v.rd ? v.s_byte : v.wd);
        chk({tag, " bus ack bit"}, rx_ack, v.rd ? v.nk : !v.s_ack);
        chk({tag, " byte count"}, n_bytes - b0, 1);
        chk({tag, " starts"}, n_start - s0, es);
        chk({tag, " stops"}, n_stop - p0, v.sp);
        @(negedge sys_clk);
        chk({tag, " rsp one cycle"}, rsp_valid, 0);
        model_held = !v.sp;
    endtask

    vec_t tbl[10];

    initial begin
        vec_t v;
        logic [7:0] exp_b;
        int         n, lat;

        //          st    sp    rd    nk    wd     s_ack s_byte lat  rdata  nack  held
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hE6, 1'b1, 8'h00, 177, 8'h00, 1'b0, 1'b0}; // write ACK
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hE6, 1'b0, 8'h00, 177, 8'h00, 1'b1, 1'b0}; // write NACK, STOP still
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hE6, 1'b1, 8'h00, 161, 8'h00, 1'b0, 1'b1}; // keep bus
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'h5A, 177, 8'h5A, 1'b0, 1'b0}; // repeated-start read
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 177, 8'h00, 1'b0, 1'b0}; // forced START
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 8'h00, 161, 8'h00, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 8'h00, 145, 8'h00, 1'b1, 1'b1}; // no START, no STOP
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hC3, 145, 8'hC3, 1'b0, 1'b1}; // read, master ACK
        tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'h81, 161, 8'h81, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'hFF, 177, 8'hFF, 1'b0, 1'b0};

        sys_rst = 1'b1; cmd_valid = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0;
        cmd_read = 1'b0; cmd_nack = 1'b0; cmd_wdata = 8'h00;
        p_rd = 1'b0; p_ack = 1'b0; p_gate = 1'b0; p_byte = 8'h00;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("reset scl", scl, 1);
        chk("reset sda", sda_w, 1);
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_rdata", rsp_rdata, 8'h00);
        chk("reset rsp_nack", rsp_nack, 0);
        chk("reset busy", busy, 0);
        chk("reset bus_held", bus_held, 0);

        for (int i = 0; i < 10; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

        // reset in the middle of a written byte
        arm(1'b0, 1'b1, 8'h00, 1'b1);
        cmd_start = 1'b1; cmd_stop = 1'b1; cmd_read = 1'b0; cmd_wdata = 8'h55; cmd_valid = 1'b1;
        wait_ready("midrst");
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        repeat (40) @(negedge sys_clk);
        chk("midrst busy before", busy, 1);
        sys_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            chk("midrst rsp_valid in reset", rsp_valid, 0);
        end
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("midrst scl", scl, 1);
        chk("midrst sda", sda_w, 1);
        chk("midrst busy", busy, 0);
        chk("midrst cmd_ready", cmd_ready, 1);
        chk("midrst bus_held", bus_held, 0);
        chk("midrst rsp_valid", rsp_valid, 0);
        model_held = 1'b0;

        // back-pressure: second command held valid with changing data while busy
        arm(1'b0, 1'b1, 8'h00, 1'b1);
        cmd_start = 1'b1; cmd_stop = 1'b0; cmd_read = 1'b0; cmd_wdata = 8'h11; cmd_valid = 1'b1;
        wait_ready("bp first");
        @(negedge sys_clk);
        cmd_start = 1'b0; cmd_stop = 1'b1; cmd_wdata = 8'($urandom);
        n = 0;
        while (!cmd_ready && n < 2000) begin
            @(negedge sys_clk);
            n++;
            if (!cmd_ready) cmd_wdata = 8'($urandom);
        end
        chk("bp ready with first rsp", rsp_valid, 1);
        chk("bp first byte", rx_byte, 8'h11);
        chk("bp first held", bus_held, 1);
        exp_b = cmd_wdata;
        arm(1'b0, 1'b1, 8'h00, 1'b0);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        cmd_wdata = ~exp_b;
        lat = 1;
        while (!rsp_valid && lat < 2000) begin @(negedge sys_clk); lat++; end
        chk("bp second latency", lat, 161);
        chk("bp second byte", rx_byte, exp_b);
        chk("bp second nack", rsp_nack, 0);
        chk("bp second held", bus_held, 0);
        model_held = 1'b0;
        @(negedge sys_clk);

        // randomized commands against the reference model
        for (int i = 0; i < 24; i++) begin
            v.st     = 1'($urandom);
            v.sp     = ($urandom_range(2) == 0);
            v.rd     = 1'($urandom);
            v.nk     = 1'($urandom);
            v.wd     = 8'($urandom);
            v.s_ack  = ($urandom_range(3) != 0);
            v.s_byte = 8'($urandom);
            v = model(v, model_held);
            run_cmd(v, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_master_byte.md
Name: i2c_master_byte

Overview:
- Parametrised byte-level I2C master; the successor to the team's fixed-sequence address-only I2C driver.
- Executes one command at a time. A command is an optional START or repeated START, one 8-bit write or read with ACK handling, then an optional STOP.
- Sits between sensor-control FSMs (e.g. gesture sensor init/readout) and the board SCL/SDA pins.
- SDA is true open-drain: driven low or released, never driven high.

Parameters:
- CLK_DIV, 125, sys_clk cycles per quarter SCL period. 50 MHz / (4*125) = 100 kHz. Legal range 4..1023.
- CNT_W, $clog2(CLK_DIV), width of the quarter-period counter. Derived; do not override.

Ports:
- sys_clk, in, 1, system clock.
- sys_rst, in, 1, synchronous active-high reset.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, block can accept a command.
- cmd_start, in, 1, issue START (or repeated START if the bus is held) before the byte.
- cmd_stop, in, 1, issue STOP after the byte.
- cmd_read, in, 1, 1 = read a byte, 0 = write cmd_wdata.
- cmd_nack, in, 1, read only: 1 = master NACKs the byte, 0 = master ACKs it.
- cmd_wdata, in, 8, byte to write, MSB first.
- rsp_valid, out, 1, one-cycle pulse when the command completes.
- rsp_rdata, out, 8, byte read. 8'h00 after a write.
- rsp_nack, out, 1, write: the slave ACK bit sampled high. Read: 0.
- busy, out, 1, command in progress.
- bus_held, out, 1, bus owned (START issued, no STOP yet).
- scl, out, 1, I2C clock (push-pull, no stretching support).
- sda, inout, 1, I2C data, open-drain.

Behaviour:
- Reset values: scl=1, sda released (z), cmd_ready=1, rsp_valid=0, rsp_rdata=8'h00, rsp_nack=0, busy=0, bus_held=0, state=IDLE.
- Reset mid-transfer returns to IDLE on the next edge and releases the bus immediately. No STOP is generated.
- Timing unit: each bus "slot" is 4 quarters q0..q3, each CLK_DIV sys_clk cycles. Quarters are produced by a qtick counter that restarts at command accept.
- Handshake:
  - cmd_ready = (state==IDLE or state==HOLD).
  - A command is accepted on an edge with cmd_valid & cmd_ready. All cmd_* fields are latched at that edge.
  - cmd_valid while not ready is ignored; the master must hold it.
- States and transitions:
  - IDLE: bus free; scl=1, sda=z.
  - START: entered on accept if cmd_start=1 or bus_held=0. A START is forced when the bus is free.
  - From START, go to WBIT if cmd_read=0, otherwise RBIT.
  - From HOLD, an accepted command with cmd_start=0 goes straight to WBIT or RBIT.
  - WBIT (8 slots) -> RACK (1 slot).
  - RBIT (8 slots) -> WACK (1 slot).
  - After the ACK slot: STOP if cmd_stop=1, else HOLD.
  - STOP -> IDLE. HOLD waits for the next command; scl=0, sda held at its last ACK-slot value.
- START slot:
  - q0: scl = bus_held?0:1, sda=z.
  - q1: scl=1, sda=z.
  - q2: scl=1, sda=0.
  - q3: scl=0, sda=0.
  - bus_held is set at the end of q3.
- Data and ACK slots: scl=0 in q0 and q3, scl=1 in q1 and q2.
  - Output data changes only at the start of q0.
  - WBIT drives sda = wdata[7-bit] (0 drives low, 1 releases).
  - RBIT and RACK release sda.
  - WACK drives 0 if cmd_nack=0, else releases.
- Sampling:
  - sda passes through a 2-flop synchroniser.
  - The sample is taken on the last sys_clk cycle of q2.
  - RBIT shifts the sample into rdata MSB-first. RACK captures the sample into rsp_nack.
- STOP slot:
  - q0: scl=0, sda=0.
  - q1: scl=1, sda=0.
  - q2 and q3: scl=1, sda=z.
  - bus_held is cleared at the end of q3.
- Completion: rsp_valid pulses for exactly one cycle, on the cycle the state enters IDLE or HOLD. rsp_rdata and rsp_nack are valid in that cycle and hold their values until the next completion.
- Latency: let S = 1 (byte) + 1 (ACK) + cmd_start + cmd_stop, where cmd_start counts as 1 if forced.
  - Write or read: rsp_valid in cycle T + 1 + (S+7)*4*CLK_DIV, where T is the accept edge.
  - So a full START+byte+ACK+STOP takes 11 slots.
- busy = not (IDLE or HOLD).
- A slave NACK does not abort the command. The remaining STOP (if requested) is still issued, and the controlling FSM decides what to do next.

Decomposition:
- Package i2c_pkg holds:
  - the state enum (IDLE, START, WBIT, RACK, RBIT, WACK, STOP, HOLD);
  - quarter-phase encodings Q0..Q3;
  - localparam BITS_PER_BYTE=8.
- One sub-module, i2c_qtick_gen (parameter CLK_DIV; inputs sys_clk, sys_rst, restart). It outputs a qtick pulse on the last cycle of each quarter, the 2-bit phase, and a last_cycle_q2 strobe.
- The FSM, shifter and pin drive stay in i2c_master_byte.

Test Plan:
- All scenarios use CLK_DIV=4 (1 slot = 16 cycles).
- Reset: assert sys_rst for 3 cycles mid-WBIT -> the next cycle shows scl=1, sda=z, busy=0, cmd_ready=1, bus_held=0, and rsp_valid stays 0.
- Write with ACK: start=1, stop=1, read=0, wdata=8'hE6; slave model ACKs -> SDA bits 1,1,1,0,0,1,1,0 appear while scl is high. rsp_valid arrives 177 cycles after accept, with rsp_nack=0 and bus_held=0 afterwards.
- Write with NACK: same command, slave leaves SDA high -> rsp_nack=1, STOP still issued (SDA rises while scl=1).
- Repeated start read: first start=1, stop=0, wdata=8'hE6. Then start=1, read=1, nack=1, stop=1, with the slave returning 8'h5A. Expected:
  - SDA rises, then falls, while scl=1 with no STOP in between;
  - master releases SDA in the ACK slot;
  - rsp_rdata=8'h5A, rsp_nack=0.
- Forced start: start=0 from IDLE, write 8'h00 -> a START slot still appears and latency equals the start=1 case.
- Back-pressure: hold cmd_valid high during busy with a changing wdata -> the command is accepted only once cmd_ready=1, and the second command uses wdata latched at its own accept edge.
